// File: rtl/pmem_loader.sv
// pmem_loader
//   Boot loader that fills the CPU program memory with RV32C halfwords from a
//   framed byte stream, holding the core in reset until a frame with a valid
//   checksum has been written.
//   Frame: SYNC, LEN_LO, LEN_HI, {DATA_LO, DATA_HI} x LEN, CSUM.
//
// Ports
//   clock       in   rising-edge clock
//   reset       in   synchronous, active-high reset
//   in_valid    in   in_data holds a byte
//   in_ready    out  loader accepts a byte this cycle (low only once done)
//   in_data     in   stream byte
//   mem_we      out  pmem write strobe, one cycle per halfword
//   mem_addr    out  pmem halfword index
//   mem_data    out  halfword {DATA_HI, DATA_LO}
//   cpu_hold    out  1 = core held in reset
//   load_done   out  valid image loaded, core released
//   load_error  out  last frame rejected (length or checksum)
module pmem_loader #(
  parameter int          ADDR_W    = 10,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_data,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_error
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA_LO, S_DATA_HI, S_CSUM, S_DONE, S_ERROR
  } state_t;

  // Largest image that fits pmem; one more halfword would wrap mem_addr.
  localparam logic [16:0] MAX_LEN = 17'd1 << ADDR_W;

  state_t              r_state;
  state_t              w_next;
  logic [15:0]         r_len;
  logic [15:0]         r_cnt;
  logic [7:0]          r_sum;
  logic [7:0]          r_lo;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [15:0]         r_data;
  logic                r_done;
  logic                r_err;

  logic                w_take;
  logic                w_write;
  logic                w_sync;
  logic [15:0]         w_len_full;
  logic [7:0]          w_sum_next;
  logic                w_last;

  assign in_ready   = (r_state != S_DONE);
  assign w_take     = in_valid && in_ready;
  assign w_len_full = {in_data, r_len[7:0]};
  assign w_sum_next = r_sum + in_data;
  assign w_last     = ((r_cnt + 16'd1) == r_len);

  assign mem_we     = r_we;
  assign mem_addr   = r_addr;
  assign mem_data   = r_data;
  assign load_done  = r_done;
  assign load_error = r_err;
  assign cpu_hold   = ~r_done;

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_write = 1'b0;
    w_sync  = 1'b0;
    if (w_take) begin
      case (r_state)
        S_IDLE, S_ERROR: begin
          if (in_data == SYNC_BYTE) begin
            w_next = S_LEN_LO;
            w_sync = 1'b1;
          end
        end
        S_LEN_LO:  w_next = S_LEN_HI;
        S_LEN_HI: begin
          if ({1'b0, w_len_full} > MAX_LEN) w_next = S_ERROR;
          else if (w_len_full == 16'd0)     w_next = S_CSUM;
          else                              w_next = S_DATA_LO;
        end
        S_DATA_LO: w_next = S_DATA_HI;
        S_DATA_HI: begin
          w_write = 1'b1;
          w_next  = w_last ? S_CSUM : S_DATA_LO;
        end
        S_CSUM:    w_next = (w_sum_next == 8'h00) ? S_DONE : S_ERROR;
        S_DONE:    w_next = S_DONE;
        default:   w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_len  <= '0;
      r_cnt  <= '0;
      r_sum  <= '0;
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      // Write is registered: strobe, index and data appear the cycle after DATA_HI.
      r_we <= w_write;
      if (w_write) begin
        r_addr <= r_cnt[ADDR_W-1:0];
        r_data <= {in_data, r_lo};
        r_cnt  <= r_cnt + 16'd1;
      end
      if (w_sync) begin
        r_sum <= '0;
        r_cnt <= '0;
        r_err <= 1'b0;
      end else if (w_take && (r_state inside {S_LEN_LO, S_LEN_HI, S_DATA_LO, S_DATA_HI})) begin
        r_sum <= w_sum_next;
      end
      if (w_take && r_state == S_LEN_LO) r_len[7:0]  <= in_data;
      if (w_take && r_state == S_LEN_HI) r_len[15:8] <= in_data;
      if (w_take && w_next == S_ERROR)   r_err       <= 1'b1;
      if (w_take && w_next == S_DONE)    r_done      <= 1'b1;
    end
  end

  // Low byte is only consumed together with its DATA_HI partner, so no reset needed.
  always_ff @(posedge clock) begin
    if (w_take && r_state == S_DATA_LO) r_lo <= in_data;
  end

endmodule

// File: tb/tb_pmem_loader.sv
module tb_pmem_loader;

  localparam int ADDR_W = 10;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [7:0]        in_data = 8'h00;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_data;
  logic              cpu_hold;
  logic              load_done;
  logic              load_error;

  pmem_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_error(load_error)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int nwrites = 0;
  int last_addr = -1;
  logic [31:0] exp_q[$];   // {addr[15:0], data[15:0]}
  logic [15:0] tx_hw[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe pops the next expected {addr,data}.
  always @(negedge clock) begin
    if (!reset && mem_we === 1'b1) begin
      logic [31:0] e;
      nwrites++;
      last_addr = int'(mem_addr);
      if (exp_q.size() == 0) begin
        check("unexpected_write", {16'(mem_addr), mem_data}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", 32'(mem_addr), 32'(e[31:16]));
        check("write_data", 32'(mem_data), 32'(e[15:0]));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit ok;
    int n;
    if (gaps) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(posedge clock);
      #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    do begin
      ok = in_ready;
      @(posedge clock);
      n++;
    end while (!ok && n < 50);
    if (!ok) check("ready_timeout", 32'd0, 32'd1);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] len, input logic [7:0] csum_xor,
                            input bit gaps, input bit no_sync);
    logic [7:0] s;
    s = 8'h00;
    if (!no_sync) send_byte(8'hA5, gaps);
    send_byte(len[7:0], gaps);  s = s + len[7:0];
    send_byte(len[15:8], gaps); s = s + len[15:8];
    if (32'(len) > (32'd1 << ADDR_W)) return;
    for (int i = 0; i < int'(len); i++) begin
      send_byte(tx_hw[i][7:0], gaps);
      s = s + tx_hw[i][7:0];
      exp_q.push_back({16'(i), tx_hw[i]});
      send_byte(tx_hw[i][15:8], gaps);
      s = s + tx_hw[i][15:8];
    end
    send_byte((8'h00 - s) ^ csum_xor, gaps);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_we"},    32'(mem_we), 32'd0);
    check({tag, "_addr"},  32'(mem_addr), 32'd0);
    check({tag, "_data"},  32'(mem_data), 32'd0);
    check({tag, "_hold"},  32'(cpu_hold), 32'd1);
    check({tag, "_done"},  32'(load_done), 32'd0);
    check({tag, "_err"},   32'(load_error), 32'd0);
  endtask

  task automatic settle_writes(input string tag, input int exp_writes, input int base);
    repeat (3) @(posedge clock);
    #1;
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_nwrites"}, 32'(nwrites - base), 32'(exp_writes));
  endtask

  int base;

  initial begin
    // Reset state
    repeat (2) @(posedge clock); #1;
    reset = 1'b0;
    check_idle("reset");

    // 1: two-halfword frame, checksum B6
    tx_hw = '{16'h4501, 16'h8082};
    base = nwrites;
    send_frame(16'd2, 8'h00, 1'b0, 1'b0);
    check("t1_done", 32'(load_done), 32'd1);
    check("t1_hold", 32'(cpu_hold), 32'd0);
    check("t1_ready", 32'(in_ready), 32'd0);
    settle_writes("t1", 2, base);

    // 2: empty frame
    do_reset();
    base = nwrites;
    send_byte(8'hA5, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
    check("t2_not_done_early", 32'(load_done), 32'd0);
    send_byte(8'h00, 1'b0);
    check("t2_done", 32'(load_done), 32'd1);
    settle_writes("t2", 0, base);

    // 3: bad checksum then corrected resend
    do_reset();
    base = nwrites;
    send_frame(16'd2, 8'h01, 1'b0, 1'b0);
    check("t3_err", 32'(load_error), 32'd1);
    check("t3_hold", 32'(cpu_hold), 32'd1);
    check("t3_ready", 32'(in_ready), 32'd1);
    check("t3_done", 32'(load_done), 32'd0);
    settle_writes("t3a", 2, base);
    base = nwrites;
    send_byte(8'hA5, 1'b0);
    check("t3_err_clr_on_sync", 32'(load_error), 32'd0);
    send_frame(16'd2, 8'h00, 1'b0, 1'b1);
    check("t3_done2", 32'(load_done), 32'd1);
    check("t3_err2", 32'(load_error), 32'd0);
    settle_writes("t3b", 2, base);

    // 4: length bound
    do_reset();
    base = nwrites;
    send_frame(16'h0401, 8'h00, 1'b0, 1'b0);
    check("t4_len_err", 32'(load_error), 32'd1);
    check("t4_len_hold", 32'(cpu_hold), 32'd1);
    settle_writes("t4a", 0, base);
    do_reset();
    tx_hw.delete();
    for (int i = 0; i < 1024; i++) tx_hw.push_back(16'((i * 37 + 5) ^ (i << 7)));
    base = nwrites;
    send_frame(16'h0400, 8'h00, 1'b0, 1'b0);
    check("t4_full_done", 32'(load_done), 32'd1);
    check("t4_full_err", 32'(load_error), 32'd0);
    settle_writes("t4b", 1024, base);
    check("t4_last_addr", 32'(last_addr), 32'd1023);

    // 5: junk prefix and random in_valid gaps
    do_reset();
    tx_hw = '{16'h4501, 16'h8082};
    base = nwrites;
    send_byte(8'h00, 1'b1); send_byte(8'hFF, 1'b1); send_byte(8'h5A, 1'b1);
    check("t5_prefix_err", 32'(load_error), 32'd0);
    check("t5_prefix_done", 32'(load_done), 32'd0);
    send_frame(16'd2, 8'h00, 1'b1, 1'b0);
    check("t5_done", 32'(load_done), 32'd1);
    check("t5_hold", 32'(cpu_hold), 32'd0);
    settle_writes("t5", 2, base);

    // 6: reset mid-frame, then normal load
    do_reset();
    base = nwrites;
    send_byte(8'hA5, 1'b0); send_byte(8'h01, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h11, 1'b0);
    do_reset();
    check_idle("t6_abort");
    settle_writes("t6a", 0, base);
    base = nwrites;
    send_frame(16'd2, 8'h00, 1'b0, 1'b0);
    check("t6_done", 32'(load_done), 32'd1);
    settle_writes("t6b", 2, base);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
